// File: rtl/maxpool_stream_ctrl_if.sv
// Stream-in, stream-out and maxpooling datapath bus of the 2x2 pooling controller.
// The master modport is the controller's view; the slave modport is its surroundings.
interface maxpool_stream_ctrl_if #(
  parameter int CH = 8
);
  logic [CH*8-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [CH*16-1:0] pool_pix12;
  logic [CH*8-1:0]  pool_pix3;
  logic [CH*8-1:0]  pool_pix4;
  logic [2:0]       pool_state;
  logic [CH*8-1:0]  pool_ans;
  logic [CH*8-1:0]  out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    input  in_data, in_valid, out_ready, pool_ans,
    output in_ready, pool_pix12, pool_pix3, pool_pix4, pool_state, out_data, out_valid
  );

  modport slave (
    output in_data, in_valid, out_ready, pool_ans,
    input  in_ready, pool_pix12, pool_pix3, pool_pix4, pool_state, out_data, out_valid
  );
endinterface

// File: rtl/maxpool_stream_ctrl.sv
// Walks a row-major pixel stream through 2x2/stride-2 max pooling: even rows fill a
// pair line buffer, odd rows assemble windows and fire the datapath for one CALC cycle.
module maxpool_stream_ctrl #(
  parameter int CH    = 8,
  parameter int MAX_W = 64,
  parameter int DIM_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_w,
  input  logic [DIM_W-1:0] cfg_h,
  output logic             busy,
  output logic             done,
  maxpool_stream_ctrl_if.master bus
);
  localparam int LB_D = MAX_W / 2;
  localparam int AW   = (LB_D > 1) ? $clog2(LB_D) : 1;
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);
  localparam logic [DIM_W-1:0] TWO = DIM_W'(2);

  typedef enum logic [2:0] {S_IDLE, S_ROW_EVEN, S_ROW_ODD, S_CALC, S_FINISH} state_t;

  state_t              state_q, state_d, ret_q, ret_d;
  logic [DIM_W-1:0]    row_q, row_d, col_q, col_d, w_q, w_d, h_q, h_d;
  logic [CH*8-1:0]     stage_q, stage_d;
  logic [CH*16-1:0]    pix12_q, pix12_d;
  logic [CH*8-1:0]     pix3_q, pix3_d, pix4_q, pix4_d;
  logic [CH*8-1:0]     out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d, done_q, done_d;

  logic [CH*16-1:0]    lbuf_q [LB_D];
  logic                lb_we;
  logic [AW-1:0]       lb_addr;
  logic [CH*16-1:0]    lb_wdata;

  logic                in_ready, in_fire, last_col, more_rows;
  logic [DIM_W:0]      row_nxt;

  // Per channel: low byte is the left (even-column) pixel, high byte the right one.
  function automatic logic [CH*16-1:0] pack_pair(input logic [CH*8-1:0] lo,
                                                 input logic [CH*8-1:0] hi);
    logic [CH*16-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) begin
      r[i*16 +: 8]   = lo[i*8 +: 8];
      r[i*16+8 +: 8] = hi[i*8 +: 8];
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    row_d       = row_q;
    col_d       = col_q;
    w_d         = w_q;
    h_d         = h_q;
    stage_d     = stage_q;
    pix12_d     = pix12_q;
    pix3_d      = pix3_q;
    pix4_d      = pix4_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    in_ready    = 1'b0;
    lb_we       = 1'b0;
    lb_addr     = col_q[AW:1];
    lb_wdata    = pack_pair(stage_q, bus.in_data);
    last_col    = (col_q == w_q - ONE);
    row_nxt     = {1'b0, row_q} + (DIM_W+1)'(1);
    more_rows   = (row_nxt < {1'b0, h_q});

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_d     = cfg_w;
          h_d     = cfg_h;
          row_d   = '0;
          col_d   = '0;
          busy_d  = 1'b1;
          state_d = (cfg_w < TWO || cfg_h < TWO) ? S_FINISH : S_ROW_EVEN;
        end
      end
      S_ROW_EVEN: begin
        in_ready = 1'b1;
      end
      S_ROW_ODD: begin
        // Stall while a result is pending so the next CALC cannot overwrite it.
        in_ready = !(out_valid_q && !bus.out_ready);
      end
      S_CALC: begin
        out_data_d  = bus.pool_ans;
        out_valid_d = 1'b1;
        state_d     = ret_q;
      end
      S_FINISH: begin
        if (!out_valid_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_fire = bus.in_valid && in_ready;

    if (in_fire) begin
      if (!col_q[0]) begin
        stage_d = bus.in_data;
      end else if (state_q == S_ROW_EVEN) begin
        lb_we = 1'b1;
      end else begin
        pix12_d = lbuf_q[lb_addr];
        pix3_d  = stage_q;
        pix4_d  = bus.in_data;
        state_d = S_CALC;
        ret_d   = !last_col ? S_ROW_ODD : (more_rows ? S_ROW_EVEN : S_FINISH);
      end

      if (last_col) begin
        col_d = '0;
        row_d = row_q + ONE;
        if (state_d != S_CALC)
          state_d = !more_rows ? S_FINISH :
                    (state_q == S_ROW_EVEN) ? S_ROW_ODD : S_ROW_EVEN;
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      w_q         <= '0;
      h_q         <= '0;
      stage_q     <= '0;
      pix12_q     <= '0;
      pix3_q      <= '0;
      pix4_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      row_q       <= row_d;
      col_q       <= col_d;
      w_q         <= w_d;
      h_q         <= h_d;
      stage_q     <= stage_d;
      pix12_q     <= pix12_d;
      pix3_q      <= pix3_d;
      pix4_q      <= pix4_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) lbuf_q[lb_addr] <= lb_wdata;
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign bus.in_ready   = in_ready;
  assign bus.pool_pix12 = pix12_q;
  assign bus.pool_pix3  = pix3_q;
  assign bus.pool_pix4  = pix4_q;
  assign bus.pool_state = (state_q == S_CALC) ? 3'd4 : 3'd0;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
endmodule

// File: tb/tb_maxpool_stream_ctrl.sv
// Directed bench for maxpool_stream_ctrl with a signed 2x2 max model standing in
// for the pooling datapath.
module tb_maxpool_stream_ctrl;
  localparam int CH    = 8;
  localparam int DIM_W = 7;
  localparam int DW    = CH*8;

  logic             clk = 1'b0;
  logic             rst, start, busy, done;
  logic [DIM_W-1:0] cfg_w, cfg_h;

  maxpool_stream_ctrl_if #(.CH(CH)) bus();

  maxpool_stream_ctrl #(.CH(CH), .MAX_W(64), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] smax(input logic [7:0] a, input logic [7:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // Datapath model: signed max of the four window pixels, zero unless computing.
  always_comb begin
    bus.pool_ans = '0;
    if (bus.pool_state == 3'd4)
      for (int i = 0; i < CH; i++)
        bus.pool_ans[i*8 +: 8] = smax(smax(bus.pool_pix12[i*16 +: 8], bus.pool_pix12[i*16+8 +: 8]),
                                      smax(bus.pool_pix3[i*8 +: 8], bus.pool_pix4[i*8 +: 8]));
  end

  logic [DW-1:0] outq[$];
  int calc_cnt, done_cnt, vld_cnt;
  int n_chk, n_fail;

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) outq.push_back(bus.out_data);
    if (bus.pool_state == 3'd4) calc_cnt++;
    if (done) done_cnt++;
    if (bus.out_valid) vld_cnt++;
  end

  function automatic logic [DW-1:0] rep(input logic [7:0] b);
    return {CH{b}};
  endfunction

  task automatic clr_mon;
    outq.delete();
    calc_cnt = 0; done_cnt = 0; vld_cnt = 0;
  endtask

  task automatic pulse_start(input int w, input int h);
    cfg_w = DIM_W'(w); cfg_h = DIM_W'(h); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pix(input logic [DW-1:0] d);
    logic ok;
    ok = 1'b0;
    bus.in_data = d; bus.in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); ok = bus.in_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    bus.in_valid = 1'b0;
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL pixel_accept: in_ready got 0, expected 1 within 100 cycles"); end
  endtask

  task automatic send_ramp(input int w, input int n);
    for (int k = 0; k < n; k++) send_pix(rep(8'((k / w) * w + (k % w))));
  endtask

  task automatic wait_done(input string nm);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    n_chk++;
    if (!got) begin n_fail++; $display("FAIL %s: done got 0, expected 1 within 200 cycles", nm); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    cfg_w = '0; cfg_h = '0;
    repeat (2) @(posedge clk); #1;
    n_chk++; if ({busy, done, bus.in_ready, bus.out_valid} !== 4'b0) begin n_fail++;
      $display("FAIL reset_ctrl: got %b, expected 0000", {busy, done, bus.in_ready, bus.out_valid}); end
    n_chk++; if (bus.pool_state !== 3'd0) begin n_fail++;
      $display("FAIL reset_pool_state: got %0d, expected 0", bus.pool_state); end
    n_chk++; if ({bus.out_data, bus.pool_pix12, bus.pool_pix3, bus.pool_pix4} !== '0) begin n_fail++;
      $display("FAIL reset_data: got %h, expected 0", {bus.out_data, bus.pool_pix12}); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [7:0] exp[4] = '{8'd5, 8'd7, 8'd13, 8'd15};
    logic [DW-1:0] got;
    clr_mon();
    pulse_start(4, 4);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b, expected 1", busy); end
    send_ramp(4, 16);
    wait_done("basic_done");
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b, expected 0", busy); end
    n_chk++; if (outq.size() !== 4) begin n_fail++; $display("FAIL basic_count: got %0d, expected 4", outq.size()); end
    for (int k = 0; k < 4; k++) begin
      got = (k < outq.size()) ? outq[k] : 'x;
      n_chk++; if (got !== rep(exp[k])) begin n_fail++;
        $display("FAIL basic_out%0d: got %h, expected %h", k, got, rep(exp[k])); end
    end
    n_chk++; if (calc_cnt !== 4) begin n_fail++; $display("FAIL basic_calc: got %0d, expected 4", calc_cnt); end
    n_chk++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d, expected 1", done_cnt); end
  endtask

  task automatic test_signed;
    logic [DW-1:0] got;
    clr_mon();
    pulse_start(2, 2);
    send_pix(rep(8'h80)); send_pix(rep(8'hFF));
    send_pix(rep(8'hFE)); send_pix(rep(8'hFD));
    wait_done("signed_done");
    got = (outq.size() > 0) ? outq[0] : 'x;
    n_chk++; if (outq.size() !== 1) begin n_fail++; $display("FAIL signed_count: got %0d, expected 1", outq.size()); end
    n_chk++; if (got !== rep(8'hFF)) begin n_fail++; $display("FAIL signed_out: got %h, expected %h", got, rep(8'hFF)); end
    n_chk++; if (calc_cnt !== 1) begin n_fail++; $display("FAIL signed_calc: got %0d, expected 1", calc_cnt); end
  endtask

  task automatic test_back_pressure;
    logic [7:0] exp[4] = '{8'd5, 8'd7, 8'd13, 8'd15};
    logic [DW-1:0] got;
    logic seen;
    clr_mon();
    bus.out_ready = 1'b0;
    pulse_start(4, 4);
    fork
      send_ramp(4, 16);
      begin
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (bus.out_valid) begin seen = 1'b1; break; end
        end
        n_chk++; if (!seen) begin n_fail++; $display("FAIL bp_valid: out_valid got 0, expected 1"); end
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          n_chk++; if (bus.out_data !== rep(8'd5)) begin n_fail++;
            $display("FAIL bp_hold%0d: got %h, expected %h", k, bus.out_data, rep(8'd5)); end
          n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++;
            $display("FAIL bp_in_ready%0d: got %b, expected 0", k, bus.in_ready); end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_done("bp_done");
    n_chk++; if (outq.size() !== 4) begin n_fail++; $display("FAIL bp_count: got %0d, expected 4", outq.size()); end
    for (int k = 0; k < 4; k++) begin
      got = (k < outq.size()) ? outq[k] : 'x;
      n_chk++; if (got !== rep(exp[k])) begin n_fail++;
        $display("FAIL bp_out%0d: got %h, expected %h", k, got, rep(exp[k])); end
    end
  endtask

  task automatic test_odd_dims;
    logic [DW-1:0] got;
    clr_mon();
    pulse_start(5, 3);
    send_ramp(5, 14);
    repeat (3) @(posedge clk); #1;
    n_chk++; if ({busy, 8'(done_cnt)} !== {1'b1, 8'd0}) begin n_fail++;
      $display("FAIL odd_early_done: got busy=%b done_cnt=%0d, expected busy=1 done_cnt=0", busy, done_cnt); end
    send_pix(rep(8'd14));
    wait_done("odd_done");
    n_chk++; if (outq.size() !== 2) begin n_fail++; $display("FAIL odd_count: got %0d, expected 2", outq.size()); end
    got = (outq.size() > 0) ? outq[0] : 'x;
    n_chk++; if (got !== rep(8'd6)) begin n_fail++; $display("FAIL odd_out0: got %h, expected %h", got, rep(8'd6)); end
    got = (outq.size() > 1) ? outq[1] : 'x;
    n_chk++; if (got !== rep(8'd8)) begin n_fail++; $display("FAIL odd_out1: got %h, expected %h", got, rep(8'd8)); end
  endtask

  task automatic test_degenerate;
    logic got;
    clr_mon();
    pulse_start(1, 4);
    got = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    n_chk++; if (!got) begin n_fail++; $display("FAIL degen_done: got 0, expected done within 2 cycles"); end
    @(posedge clk); #1;
    n_chk++; if (calc_cnt !== 0) begin n_fail++; $display("FAIL degen_calc: got %0d, expected 0", calc_cnt); end
    n_chk++; if (vld_cnt !== 0) begin n_fail++; $display("FAIL degen_valid: got %0d, expected 0", vld_cnt); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL degen_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_mid_reset;
    logic [DW-1:0] got;
    clr_mon();
    pulse_start(4, 4);
    send_ramp(4, 6);
    rst = 1'b1;
    @(posedge clk); #1;
    n_chk++; if ({busy, done, bus.in_ready, bus.out_valid, bus.pool_state} !== 7'b0) begin n_fail++;
      $display("FAIL mid_rst_ctrl: got %b, expected 0", {busy, done, bus.in_ready, bus.out_valid, bus.pool_state}); end
    n_chk++; if ({bus.out_data, bus.pool_pix12, bus.pool_pix3, bus.pool_pix4} !== '0) begin n_fail++;
      $display("FAIL mid_rst_data: got %h, expected 0", {bus.out_data, bus.pool_pix4}); end
    rst = 1'b0;
    clr_mon();
    pulse_start(2, 2);
    send_pix(rep(8'd1));
    pulse_start(1, 1);
    send_pix(rep(8'd2)); send_pix(rep(8'd3)); send_pix(rep(8'd4));
    wait_done("mid_done");
    n_chk++; if (outq.size() !== 1) begin n_fail++; $display("FAIL mid_count: got %0d, expected 1", outq.size()); end
    got = (outq.size() > 0) ? outq[0] : 'x;
    n_chk++; if (got !== rep(8'd4)) begin n_fail++; $display("FAIL mid_out: got %h, expected %h", got, rep(8'd4)); end
    n_chk++; if (done_cnt !== 1) begin n_fail++; $display("FAIL mid_done_cnt: got %0d, expected 1", done_cnt); end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    clr_mon();
    test_reset();
    test_basic();
    test_signed();
    test_back_pressure();
    test_odd_dims();
    test_degenerate();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
